// File: rtl/weight_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : weight_fifo_pkg
//  Description : Shared types and constants for the weight FIFO drain path.
//                - state_t         : drain controller FSM encoding
//                - c_fifo_rd_lat   : FIFO read latency (pop -> data valid)
//                - cnt_width()     : width of the drain/flush slot counter
//  Revision    : 1.0 - initial release
// ============================================================================
package weight_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOAD = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_FLUSH     = 2'd3
    } state_t;

    // Cycles from a FIFO pop until the popped word is on the FIFO output.
    localparam int c_fifo_rd_lat = 1;

    // The counter must hold depth+width without wrapping.
    function automatic int cnt_width(input int depth, input int width);
        return $clog2(depth + width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_out_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_out_ctrl_if
//  Description : Control/status bundle between the drain controller, the
//                weight FIFO bank and the PE array.
//                en, weights_ready, stall : requests into the controller
//                fifo_pop, w_load         : per-lane pop / per-column load
//                busy, done               : controller status
//                modport master = controller, modport slave = environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_out_ctrl_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  en;
    logic                  weights_ready;
    logic                  stall;
    logic [FIFO_WIDTH-1:0] fifo_pop;
    logic [FIFO_WIDTH-1:0] w_load;
    logic                  busy;
    logic                  done;

    modport master (
        input  en, weights_ready, stall,
        output fifo_pop, w_load, busy, done
    );

    modport slave (
        output en, weights_ready, stall,
        input  fifo_pop, w_load, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/skew_line.sv
`default_nettype none
// ============================================================================
//  Module      : skew_line
//  Description : WIDTH-tap diagonal skew shift register.
//                clk, rstn : clock, asynchronous active-low reset
//                shift_en  : advance the line by one slot
//                serial_in : lane-0 value for the current slot
//                taps      : taps[0] = serial_in (pass-through),
//                            taps[i] = serial_in from i advances ago
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_line #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] taps
);

    generate
        if (WIDTH > 1) begin : g_line
            // r_tap[j] holds the lane-(j+1) value for the current slot.
            logic [WIDTH-2:0] r_tap;

            assign taps = {r_tap, serial_in};

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_tap <= '0;
                end else if (shift_en) begin
                    r_tap <= taps[WIDTH-2:0];
                end
            end
        end else begin : g_pass
            assign taps = serial_in;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fifo_out_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_out_ctrl
//  Description : Drain-side controller for the weight FIFO bank. Pops
//                FIFO_DEPTH entries from each of FIFO_WIDTH lanes with a
//                diagonal skew (lane i lags lane 0 by i advancing cycles),
//                raises w_load one read-latency after each pop and pulses
//                done after the last column has loaded.
//                clk  : clock
//                rstn : asynchronous active-low reset
//                bus  : fifo_out_ctrl_if.master (en, weights_ready, stall in;
//                       fifo_pop, w_load, busy, done out, all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_out_ctrl
    import weight_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rstn,
    fifo_out_ctrl_if.master     bus
);

    localparam int CNT_WIDTH = cnt_width(FIFO_DEPTH, FIFO_WIDTH);

    // Slot index of the last lane-0 pop.
    localparam logic [CNT_WIDTH-1:0] c_last_pop = CNT_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_depth    = CNT_WIDTH'(FIFO_DEPTH);
    // Counter value on the edge that raises done, and on the edge that
    // returns to IDLE (done is visible for exactly one cycle in between).
    localparam logic [CNT_WIDTH-1:0] c_done_cnt = CNT_WIDTH'(FIFO_DEPTH + FIFO_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_end_cnt  = CNT_WIDTH'(FIFO_DEPTH + FIFO_WIDTH);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic [CNT_WIDTH-1:0]  w_slot;
    logic                  w_enter;
    logic                  w_run;
    logic                  w_adv;
    logic                  w_lane0;
    logic [FIFO_WIDTH-1:0] w_taps;
    logic [FIFO_WIDTH-1:0] w_pop_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [FIFO_WIDTH-1:0] r_pop;
    logic                  r_busy;
    logic                  r_done;
    logic [FIFO_WIDTH-1:0] r_load_pipe [c_fifo_rd_lat];

    // ------------------------------------------------------------------
    // State, counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pop   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pop   <= w_pop_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_enter = (r_state == ST_WAIT_LOAD) && bus.weights_ready;
        w_run   = ((r_state == ST_DRAIN) || (r_state == ST_FLUSH)) && !bus.stall;
        // Slot being issued on this edge: entry edge is slot 0.
        w_slot  = w_enter ? '0 : (r_cnt + CNT_WIDTH'(1));

        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.en) begin
                    w_state_nxt = ST_WAIT_LOAD;
                end
            end
            ST_WAIT_LOAD: begin
                if (w_enter) begin
                    w_state_nxt = (w_slot >= c_last_pop) ? ST_FLUSH : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_run && (w_slot >= c_last_pop)) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_run && (r_cnt == c_end_cnt)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        // The skew line only advances on a slot, so a stall freezes the
        // wavefront and resumes it without losing or repeating a pop.
        w_adv   = w_enter || w_run;
        w_lane0 = w_adv && (w_slot < c_depth);

        w_cnt_nxt = r_cnt;
        if (w_enter) begin
            w_cnt_nxt = '0;
        end else if (w_run && (w_state_nxt != ST_IDLE)) begin
            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end

        w_pop_nxt  = w_adv ? w_taps : '0;
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = w_run && (r_state == ST_FLUSH) && (r_cnt == c_done_cnt);
    end

    skew_line #(
        .WIDTH (FIFO_WIDTH)
    ) u_skew_line (
        .clk       (clk),
        .rstn      (rstn),
        .shift_en  (w_adv),
        .serial_in (w_lane0),
        .taps      (w_taps)
    );

    // w_load follows fifo_pop by the FIFO read latency and ignores stall,
    // so words already popped still reach the array.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < c_fifo_rd_lat; k++) begin
                r_load_pipe[k] <= '0;
            end
        end else begin
            r_load_pipe[0] <= r_pop;
            for (int k = 1; k < c_fifo_rd_lat; k++) begin
                r_load_pipe[k] <= r_load_pipe[k-1];
            end
        end
    end

    assign bus.fifo_pop = r_pop;
    assign bus.w_load   = r_load_pipe[c_fifo_rd_lat-1];
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire
